// File: rtl/fifo_sync.sv
// Synchronous FIFO with a pointer-difference occupancy count and sticky overflow/underflow flags.
// The read port is either first-word-fall-through or registered on pop, chosen by FWFT.
module fifo_sync #(
    parameter int DW        = 104,
    parameter int AW        = 2,
    parameter int AFULL_LVL = (1 << AW) - 1,
    parameter int FWFT      = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_write,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_read,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          full,
    output logic          almost_full,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int         MD      = 1 << AW;
    localparam logic [AW:0] MD_C    = (AW+1)'(MD);
    localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_LVL);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [DW-1:0] mem_q [MD];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_accept, rd_accept;

    // Flags come purely from the registered pointers; the wrap bit disambiguates full from empty.
    assign count       = wr_ptr_q - rd_ptr_q;
    assign empty       = (count == '0);
    assign full        = (count == MD_C);
    assign almost_full = (count >= AFULL_C);
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // Full is checked on the pre-edge state, so a same-cycle pop never makes room for a write.
    assign wr_accept = wr_write && !full && !reset;
    assign rd_accept = rd_read && !empty && !reset;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end
        if (wr_write && full) begin
            overflow_d = 1'b1;
        end
        if (rd_read && empty) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
        end else begin : g_reg_read
            logic [DW-1:0] rd_data_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_data_q <= '0;
                end else if (rd_accept) begin
                    rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
                end
            end

            assign rd_data = rd_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: a vector table on an FWFT instance plus hand sequences
// for wrap, mid-operation reset and the registered-read instance.
module tb_fifo_sync;

    localparam int DW = 104;
    localparam int AW = 2;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT instance (a_*) and registered-read instance (b_*)
    logic          a_reset = 1'b0, a_wr = 1'b0, a_rd = 1'b0;
    logic [DW-1:0] a_wdata = '0, a_rdata;
    logic          a_empty, a_full, a_afull, a_ovf, a_unf;
    logic [AW:0]   a_count;

    logic          b_reset = 1'b0, b_wr = 1'b0, b_rd = 1'b0;
    logic [DW-1:0] b_wdata = '0, b_rdata;
    logic          b_empty, b_full, b_afull, b_ovf, b_unf;
    logic [AW:0]   b_count;

    fifo_sync #(.DW(DW), .AW(AW), .FWFT(1)) dut_a (
        .clk(clk), .reset(a_reset), .wr_write(a_wr), .wr_data(a_wdata),
        .rd_read(a_rd), .rd_data(a_rdata), .empty(a_empty), .full(a_full),
        .almost_full(a_afull), .count(a_count), .overflow(a_ovf), .underflow(a_unf)
    );

    fifo_sync #(.DW(DW), .AW(AW), .FWFT(0)) dut_b (
        .clk(clk), .reset(b_reset), .wr_write(b_wr), .wr_data(b_wdata),
        .rd_read(b_rd), .rd_data(b_rdata), .empty(b_empty), .full(b_full),
        .almost_full(b_afull), .count(b_count), .overflow(b_ovf), .underflow(b_unf)
    );

    typedef struct {
        logic          rst, wr, rd;
        logic [DW-1:0] wd;
        logic [AW:0]   c;
        logic          e, f, af, ov, un;
        logic          dchk;
        logic [DW-1:0] d;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic vec_t v(logic rst, logic wr, logic rd, logic [DW-1:0] wd, int c,
                               logic e, logic f, logic af, logic ov, logic un,
                               logic dchk, logic [DW-1:0] d);
        vec_t r;
        r.rst = rst; r.wr = wr; r.rd = rd; r.wd = wd; r.c = (AW+1)'(c);
        r.e = e; r.f = f; r.af = af; r.ov = ov; r.un = un; r.dchk = dchk; r.d = d;
        return r;
    endfunction

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_a(logic rst, logic wr, logic rd, logic [DW-1:0] wd);
        a_reset = rst; a_wr = wr; a_rd = rd; a_wdata = wd;
        @(posedge clk); #1;
        a_reset = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic step_b(logic rst, logic wr, logic rd, logic [DW-1:0] wd);
        b_reset = rst; b_wr = wr; b_rd = rd; b_wdata = wd;
        @(posedge clk); #1;
        b_reset = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
    endtask

    initial begin
        // fill/drain with overflow on a full FIFO and underflow on an empty one
        vecs.push_back(v(1,0,0,'h0 , 0, 1,0,0,0,0, 0,'h0));
        vecs.push_back(v(0,1,0,'h1 , 1, 0,0,0,0,0, 1,'h1));
        vecs.push_back(v(0,1,0,'h2 , 2, 0,0,0,0,0, 1,'h1));
        vecs.push_back(v(0,1,0,'h3 , 3, 0,0,1,0,0, 1,'h1));
        vecs.push_back(v(0,1,0,'h4 , 4, 0,1,1,0,0, 1,'h1));
        vecs.push_back(v(0,1,0,'h5 , 4, 0,1,1,1,0, 1,'h1));
        vecs.push_back(v(0,0,1,'h0 , 3, 0,0,1,1,0, 1,'h2));
        vecs.push_back(v(0,0,1,'h0 , 2, 0,0,0,1,0, 1,'h3));
        vecs.push_back(v(0,0,1,'h0 , 1, 0,0,0,1,0, 1,'h4));
        vecs.push_back(v(0,0,1,'h0 , 0, 1,0,0,1,0, 0,'h0));
        vecs.push_back(v(0,0,1,'h0 , 0, 1,0,0,1,1, 0,'h0));
        // reset wins over simultaneous requests
        vecs.push_back(v(1,1,1,'h99, 0, 1,0,0,0,0, 0,'h0));
        // full FIFO, write 0xAA together with a pop: write is lost
        vecs.push_back(v(0,1,0,'h11, 1, 0,0,0,0,0, 1,'h11));
        vecs.push_back(v(0,1,0,'h22, 2, 0,0,0,0,0, 1,'h11));
        vecs.push_back(v(0,1,0,'h33, 3, 0,0,1,0,0, 1,'h11));
        vecs.push_back(v(0,1,0,'h44, 4, 0,1,1,0,0, 1,'h11));
        vecs.push_back(v(0,1,1,'hAA, 3, 0,0,1,1,0, 1,'h22));
        vecs.push_back(v(0,0,1,'h0 , 2, 0,0,0,1,0, 1,'h33));
        vecs.push_back(v(0,0,1,'h0 , 1, 0,0,0,1,0, 1,'h44));
        vecs.push_back(v(0,0,1,'h0 , 0, 1,0,0,1,0, 0,'h0));
        vecs.push_back(v(0,1,0,'h55, 1, 0,0,0,1,0, 1,'h55));
        vecs.push_back(v(1,0,0,'h0 , 0, 1,0,0,0,0, 0,'h0));

        step_b(1'b1, 1'b0, 1'b0, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            step_a(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].wd);
            chk($sformatf("vec%0d.count", i), DW'(a_count), DW'(vecs[i].c));
            chk($sformatf("vec%0d.empty", i), DW'(a_empty), DW'(vecs[i].e));
            chk($sformatf("vec%0d.full",  i), DW'(a_full),  DW'(vecs[i].f));
            chk($sformatf("vec%0d.afull", i), DW'(a_afull), DW'(vecs[i].af));
            chk($sformatf("vec%0d.ovf",   i), DW'(a_ovf),   DW'(vecs[i].ov));
            chk($sformatf("vec%0d.unf",   i), DW'(a_unf),   DW'(vecs[i].un));
            if (vecs[i].dchk) chk($sformatf("vec%0d.rdata", i), a_rdata, vecs[i].d);
            $display("vec%0d rst=%0b wr=%0b rd=%0b wd=%0h -> count=%0d empty=%0b full=%0b af=%0b ovf=%0b unf=%0b rdata=%0h",
                     i, vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].wd, a_count, a_empty,
                     a_full, a_afull, a_ovf, a_unf, a_rdata);
        end

        // wrap: hold count at 2 with simultaneous write/read for 10 cycles
        step_a(1'b0, 1'b1, 1'b0, 'h100);
        step_a(1'b0, 1'b1, 1'b0, 'h101);
        for (int k = 0; k < 10; k++) begin
            step_a(1'b0, 1'b1, 1'b1, DW'('h102 + k));
            chk($sformatf("wrap%0d.count", k), DW'(a_count), DW'(2));
            chk($sformatf("wrap%0d.rdata", k), a_rdata, DW'('h101 + k));
            $display("wrap%0d count=%0d rdata=%0h", k, a_count, a_rdata);
        end

        // mid-operation reset with a write presented alongside
        step_a(1'b1, 1'b0, 1'b0, '0);
        step_a(1'b0, 1'b0, 1'b1, '0);
        chk("mid.unf_set", DW'(a_unf), DW'(1));
        step_a(1'b0, 1'b1, 1'b0, 'h1);
        step_a(1'b0, 1'b1, 1'b0, 'h2);
        step_a(1'b0, 1'b1, 1'b0, 'h3);
        chk("mid.count3", DW'(a_count), DW'(3));
        step_a(1'b1, 1'b1, 1'b0, 'hEE);
        chk("mid.count0", DW'(a_count), DW'(0));
        chk("mid.empty", DW'(a_empty), DW'(1));
        chk("mid.unf_clr", DW'(a_unf), DW'(0));
        chk("mid.afull", DW'(a_afull), DW'(0));
        step_a(1'b0, 1'b1, 1'b0, 'h7);
        chk("mid.rdata7", a_rdata, DW'('h7));
        chk("mid.count1", DW'(a_count), DW'(1));
        step_a(1'b0, 1'b0, 1'b1, '0);
        chk("mid.empty_after", DW'(a_empty), DW'(1));
        $display("midreset done count=%0d empty=%0b", a_count, a_empty);

        // registered-read instance
        step_b(1'b1, 1'b0, 1'b0, '0);
        chk("reg.rst_rdata", b_rdata, '0);
        chk("reg.rst_empty", DW'(b_empty), DW'(1));
        step_b(1'b0, 1'b1, 1'b0, 'h5);
        chk("reg.prepop_rdata", b_rdata, '0);
        chk("reg.count1", DW'(b_count), DW'(1));
        step_b(1'b0, 1'b0, 1'b1, '0);
        chk("reg.pop_rdata", b_rdata, DW'('h5));
        chk("reg.pop_empty", DW'(b_empty), DW'(1));
        for (int k = 0; k < 2; k++) begin
            step_b(1'b0, 1'b0, 1'b0, '0);
            chk($sformatf("reg.hold%0d", k), b_rdata, DW'('h5));
        end
        step_b(1'b0, 1'b1, 1'b0, 'h9);
        step_b(1'b0, 1'b1, 1'b0, 'hA);
        step_b(1'b0, 1'b0, 1'b1, '0);
        chk("reg.pop9", b_rdata, DW'('h9));
        step_b(1'b0, 1'b0, 1'b0, '0);
        chk("reg.hold9", b_rdata, DW'('h9));
        step_b(1'b0, 1'b0, 1'b1, '0);
        chk("reg.popA", b_rdata, DW'('hA));
        step_b(1'b0, 1'b0, 1'b1, '0);
        chk("reg.underflow_rdata", b_rdata, DW'('hA));
        chk("reg.underflow", DW'(b_unf), DW'(1));
        $display("regread done rdata=%0h unf=%0b", b_rdata, b_unf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 SHALL have parameter DW, default 104, data width in bits.
REQ-002 SHALL have parameter AW, default 2, address width; depth MD = 2^AW entries.
REQ-003 SHALL have parameter AFULL_LVL, default MD-1, occupancy at or above which almost_full asserts; legal range 1..MD.
REQ-004 SHALL have parameter FWFT, default 1; 1 = first-word-fall-through read, 0 = registered read.
REQ-005 SHALL have port clk, input, 1, single clock for all logic; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port wr_write, input, 1, write request.
REQ-008 SHALL have port wr_data, input, DW, write data.
REQ-009 SHALL have port rd_read, input, 1, read request / pop.
REQ-010 SHALL have port rd_data, output, DW, read data.
REQ-011 SHALL have port empty, output, 1, no entries stored.
REQ-012 SHALL have port full, output, 1, MD entries stored.
REQ-013 SHALL have port almost_full, output, 1, count >= AFULL_LVL.
REQ-014 SHALL have port count, output, AW+1, current occupancy 0..MD.
REQ-015 SHALL have port overflow, output, 1, sticky: a write was attempted while full.
REQ-016 SHALL have port underflow, output, 1, sticky: a read was attempted while empty.

Function
REQ-017 SHALL hold MD x DW storage; storage SHALL NOT be reset.
REQ-018 SHALL keep wr_ptr and rd_ptr of AW+1 bits; low AW bits address storage, MSB is wrap bit; both increment modulo 2^(AW+1).
REQ-019 SHALL accept a write iff wr_write=1 and full=0: store wr_data at wr_ptr, increment wr_ptr.
REQ-020 SHALL accept a read iff rd_read=1 and empty=0: increment rd_ptr.
REQ-021 SHALL reject a write while full even if a read is accepted in the same cycle; the write is lost and overflow sets.
REQ-022 SHALL, on simultaneous accepted read and write, leave count unchanged.
REQ-023 SHALL compute count = wr_ptr - rd_ptr (AW+1 bits); empty = (count==0); full = (count==MD); almost_full = (count>=AFULL_LVL); all outputs derived only from registered state, never combinationally from wr_write or rd_read.
REQ-024 SHALL make a write to an empty FIFO visible as empty=0 on the cycle after the accepting edge.
REQ-025 SHALL, with FWFT=1, drive rd_data = storage[rd_ptr] combinationally; valid whenever empty=0; don't-care while empty.
REQ-026 SHALL, with FWFT=0, register rd_data <= storage[rd_ptr] on an accepted read (data valid the cycle after the pop); rd_data holds its value otherwise.
REQ-027 SHALL set overflow on any edge where wr_write=1 and full=1; set underflow on any edge where rd_read=1 and empty=1; both stay set until reset.
REQ-028 SHALL not alter pointers, storage or count on rejected requests.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, set wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_full=0 (AFULL_LVL>=1), overflow=0, underflow=0, and rd_data=0 when FWFT=0.
REQ-030 SHALL give reset priority over wr_write and rd_read in the same cycle; requests presented with reset are ignored and do not set flags.
REQ-031 SHALL discard all stored entries on reset asserted mid-operation; first post-reset read returns the first post-reset write.

Verification
REQ-032 SHALL cover fill/drain (AW=2, FWFT=1): write 1,2,3,4 -> full=1, count=4, almost_full=1 from count=3; read 4 times -> rd_data 1,2,3,4 in order, empty=1.
REQ-033 SHALL cover overflow: full FIFO, wr_write=1 data 0xAA with rd_read=1 -> one entry popped, 0xAA not stored, count=3, overflow=1 until reset.
REQ-034 SHALL cover underflow: empty FIFO, rd_read=1 -> count stays 0, rd_ptr unchanged, underflow=1.
REQ-035 SHALL cover wrap: 10 cycles of simultaneous write/read at count=2 -> count constant 2, data order preserved across pointer wrap.
REQ-036 SHALL cover FWFT=0: write 0x5, then rd_read=1 -> rd_data=0x5 one cycle after the pop edge, held while rd_read=0.
REQ-037 SHALL cover mid-operation reset: count=3, reset=1 with wr_write=1 -> next cycle count=0, empty=1, flags clear; write 0x7 then read -> 0x7.
